// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter: registered one-hot grant plus index, held until released.
// Optional grant-hold limit is compiled in with `define ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       valid,
    output logic       timeout
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;

    logic [3:0] elig;
    logic [1:0] cand [4];
    logic       found;
    logic [1:0] pick;
    logic       force_rel;

    // Search order: ptr, ptr+1, ptr+2, ptr+3, wrapping naturally in 2 bits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi] = ptr_q + 2'(gi);
    end

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found && elig[cand[k]]) begin
                found = 1'b1;
                pick  = cand[k];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] CNT_LAST = 5'(HOLD_MAX - 1);

    logic [4:0] cnt_q, cnt_d;
    logic [3:0] blk_q, blk_d;
    logic       timeout_q, timeout_d;

    // A revoked client stays masked until it drops its request.
    assign elig      = req & ~blk_q;
    assign force_rel = (state_q == GRANT) && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        blk_d     = blk_q & req;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (en && req[idx_q]) begin
            if (force_rel) begin
                blk_d[idx_q] = 1'b1;
                timeout_d    = 1'b1;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            blk_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            blk_q     <= blk_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_hold;
    assign unused_hold = ^5'(HOLD_MAX);
    assign elig        = req;
    assign force_rel   = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (en && found) begin
                    state_d = GRANT;
                    idx_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (!en || !req[idx_q] || force_rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign valid   = valid_q;
endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares a single 2-to-4 decoded resource between four clients. It selects one requester, drives the 2-bit grant index and the matching one-hot grant vector, and holds the grant until the owner releases it. Rotating priority prevents starvation. It sits between client request lines and the decoder-steered shared resource.

## Interface
Parameters:
- HOLD_MAX, 16: maximum consecutive cycles one grant may be held. Only used when ARB_TIMEOUT_EN is defined. Legal range 2..31.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- en  in  1  arbiter enable. Low means no new grant is issued and any current grant is released.
- req  in  4  request lines. req[n] is held high by client n for the whole time it wants or owns the resource.
- gnt  out  4  one-hot grant, equal to the 2-to-4 decode of gnt_idx while valid=1. All zero when valid=0.
- gnt_idx  out  2  index of the granted client. Holds its last value while valid=0.
- valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked. Constant 0 when ARB_TIMEOUT_EN is undefined.

## Operation
- All outputs are registered.
- Internal state:
  - FSM with states IDLE and GRANT.
  - 2-bit priority pointer ptr.
  - 5-bit hold counter cnt, present only with ARB_TIMEOUT_EN.
- Reset values: state=IDLE, ptr=0, cnt=0, gnt=4'b0000, gnt_idx=2'b00, valid=0, timeout=0.
- IDLE:
  - If en=1 and req≠0, pick the first n with req[n]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Then set gnt_idx=n, gnt=1<<n, valid=1, cnt=0, and go to GRANT.
  - Otherwise stay in IDLE with outputs cleared (gnt_idx unchanged).
- GRANT:
  - Stay while en=1 and req[gnt_idx]=1. Requests from other clients are ignored.
  - Release condition: req[gnt_idx]=0 or en=0. On release: valid=0, gnt=0, ptr=gnt_idx+1 (wraps 3→0), go to IDLE.
- Every release passes through at least one IDLE cycle. There is no back-to-back grant.
- Simultaneous requests in IDLE: the pointer search order decides. Example: ptr=2, req=4'b1011 → grant client 3.
- A request that drops in the same cycle it would have been granted is not granted, because only the sampled req is used.
- Reset asserted mid-grant clears all outputs immediately, with no clock needed. After reset, ptr=0.

## Timing
- Grant latency: req sampled high at rising edge k while in IDLE → gnt/valid high after edge k. That is 1 cycle from the request being visible.
- Release latency: req[gnt_idx] sampled low at edge k → gnt=0 after edge k. The earliest next grant appears after edge k+1.
- Worst-case wait for a continuously requesting client with 3 competitors: 3 grants plus 3 IDLE cycles.
- gnt and gnt_idx change only together and only on clock edges. gnt is never multi-hot.

## Configuration
- ARB_TIMEOUT_EN defined:
  - cnt increments every GRANT cycle.
  - If the release condition has not occurred and cnt=HOLD_MAX-1, the grant is released on that edge. gnt has then been high for exactly HOLD_MAX cycles.
  - A forced release sets ptr=gnt_idx+1, goes to IDLE, and pulses timeout=1 for the one cycle in which valid=0.
  - The revoked client must deassert req before it can be granted again. While its req stays high, it is skipped in the pointer search.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and the HOLD_MAX parameter is unused.
  - A grant is held indefinitely; timeout is tied 0.

## Test plan
- Reset mid-grant: client 1 granted, rst pulsed between edges → gnt=0, valid=0, gnt_idx=0 asynchronously. Then req=4'b0010 gives a grant with gnt=4'b0010 one cycle after rst is released.
- Rotation: req=4'b1111 held, each owner drops its req for one cycle after 2 cycles of grant → grant order 0,1,2,3,0, with exactly one IDLE cycle between grants.
- Pointer wrap: client 3 granted, then released with req=4'b1001 pending → next gnt=4'b0001 and ptr=0 before grant.
- Enable: grant to client 2 active, en=0 for one cycle → gnt=0 on the next edge. en=1 with req=4'b0100 still high → client 2 is re-granted only if no higher-priority requester from ptr=3 is pending. With req=4'b1100, client 3 is granted.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): client 0 holds req high → gnt=4'b0001 for exactly 4 cycles, then timeout=1 for 1 cycle. Client 1 (req high) is granted on the following edge and client 0 is not re-granted until its req toggles.
- No-timeout build: same stimulus → gnt=4'b0001 held for 100 cycles, timeout never 1.
